// File: rtl/operand_hazard_unit.sv
// operand_hazard_unit: decode-stage operand bypass and hazard detection.
// Each source operand is taken from the youngest matching forwarding stage,
// or from the regfile when no stage matches. A scoreboard tracks registers
// owed by variable-latency writers, and a busy counter tracks the mult/div
// unit that owns HI/LO. Any hazard on a used operand raises a decode stall.
// A saturating counter records how many cycles decode spent stalled.
module operand_hazard_unit #(
  parameter int AW        = 5,
  parameter int DW        = 32,
  parameter int NRP       = 2,
  parameter int NFS       = 3,
  parameter int MD_CYCLES = 33
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [NRP*AW-1:0]     rd_addr,
  input  logic [NRP-1:0]        rd_used,
  input  logic [NRP*DW-1:0]     rf_data,
  output logic [NRP*DW-1:0]     rd_value,
  input  logic                  id_we,
  input  logic [AW-1:0]         id_dest,
  input  logic                  id_hilo,
  input  logic [NFS-1:0]        fwd_wena,
  input  logic [NFS*AW-1:0]     fwd_dest,
  input  logic [NFS*DW-1:0]     fwd_data,
  input  logic [NFS-1:0]        fwd_ready,
  input  logic                  issue_fire,
  input  logic                  issue_long,
  input  logic                  wb_long_done,
  input  logic [AW-1:0]         wb_long_dest,
  input  logic                  md_start,
  output logic                  stall,
  output logic                  md_busy,
  output logic [(1<<AW)-1:0]    sb_pending,
  output logic [31:0]           stall_cycles
);

  localparam int NREG = 1 << AW;
  localparam int MDW  = $clog2(MD_CYCLES);
  localparam logic [MDW-1:0] MD_LOAD = MDW'(MD_CYCLES - 1);

  // Saturating increment: the stall counter sticks at all-ones.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [NREG-1:0]   r_sb;
  logic [MDW-1:0]    r_md_cnt;
  logic [31:0]       r_stall_cnt;

  logic [NRP*DW-1:0] w_rd_value;
  logic [NRP-1:0]    w_hit;
  logic [NRP-1:0]    w_raw_hz;
  logic              w_waw_hz;
  logic              w_hilo_hz;
  logic              w_md_busy;
  logic              w_stall;
  logic [NREG-1:0]   w_sb_next;

  // Operand select and RAW detection; stages are walked oldest-first so the
  // youngest matching stage is the one that sticks.
  always_comb begin
    w_rd_value = rf_data;
    w_hit      = '0;
    w_raw_hz   = '0;
    for (int p = 0; p < NRP; p++) begin
      for (int k = NFS - 1; k >= 0; k--) begin
        if (fwd_wena[k] && (fwd_dest[k*AW +: AW] == rd_addr[p*AW +: AW]) &&
            (rd_addr[p*AW +: AW] != '0)) begin
          w_hit[p]               = 1'b1;
          w_rd_value[p*DW +: DW] = fwd_data[k*DW +: DW];
          w_raw_hz[p]            = ~fwd_ready[k];
        end
      end
      // A stage match means the value is in flight there; the pending bit
      // only matters when nothing in the pipe carries the register.
      if (!w_hit[p] && (rd_addr[p*AW +: AW] != '0) && r_sb[rd_addr[p*AW +: AW]])
        w_raw_hz[p] = 1'b1;
    end
  end

  // WAW, HI/LO and the combined decode stall.
  always_comb begin
    w_md_busy = (r_md_cnt != '0);
    w_waw_hz  = id_we && (id_dest != '0) && r_sb[id_dest];
    w_hilo_hz = id_hilo && w_md_busy;
    w_stall   = id_valid && ((|(w_raw_hz & rd_used)) || w_waw_hz || w_hilo_hz);
  end

  // Scoreboard next state: clear on retire, set on long issue; set is applied
  // last so it wins when both target the same register.
  always_comb begin
    w_sb_next = r_sb;
    if (wb_long_done)
      w_sb_next[wb_long_dest] = 1'b0;
    if (issue_fire && issue_long && id_we && (id_dest != '0))
      w_sb_next[id_dest] = 1'b1;
    w_sb_next[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (reset) r_sb <= '0;
    else       r_sb <= w_sb_next;
  end

  // Mult/div occupancy counter; a start always reloads.
  always_ff @(posedge clk) begin
    if (reset)                r_md_cnt <= '0;
    else if (md_start)        r_md_cnt <= MD_LOAD;
    else if (r_md_cnt != '0)  r_md_cnt <= r_md_cnt - MDW'(1);
  end

  // Stall-cycle counter, saturating.
  always_ff @(posedge clk) begin
    if (reset)        r_stall_cnt <= '0;
    else if (w_stall) r_stall_cnt <= sat_inc(r_stall_cnt);
  end

  assign rd_value     = w_rd_value;
  assign stall        = w_stall;
  assign md_busy      = w_md_busy;
  assign sb_pending   = r_sb;
  assign stall_cycles = r_stall_cnt;

endmodule

// File: tb/tb_operand_hazard_unit.sv
// Bench for operand_hazard_unit: directed scenarios plus random traffic,
// checked cycle by cycle against a behavioural model via an expectation queue.
module tb_operand_hazard_unit;

  localparam int AW = 5, DW = 32, NRP = 2, NFS = 3, MD = 33;
  localparam int NREG = 1 << AW;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 id_valid;
  logic [NRP*AW-1:0]    rd_addr;
  logic [NRP-1:0]       rd_used;
  logic [NRP*DW-1:0]    rf_data;
  logic [NRP*DW-1:0]    rd_value;
  logic                 id_we;
  logic [AW-1:0]        id_dest;
  logic                 id_hilo;
  logic [NFS-1:0]       fwd_wena;
  logic [NFS*AW-1:0]    fwd_dest;
  logic [NFS*DW-1:0]    fwd_data;
  logic [NFS-1:0]       fwd_ready;
  logic                 issue_fire, issue_long, wb_long_done;
  logic [AW-1:0]        wb_long_dest;
  logic                 md_start;
  logic                 stall, md_busy;
  logic [NREG-1:0]      sb_pending;
  logic [31:0]          stall_cycles;

  operand_hazard_unit #(.AW(AW), .DW(DW), .NRP(NRP), .NFS(NFS), .MD_CYCLES(MD)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .rd_addr(rd_addr),
    .rd_used(rd_used), .rf_data(rf_data), .rd_value(rd_value), .id_we(id_we),
    .id_dest(id_dest), .id_hilo(id_hilo), .fwd_wena(fwd_wena), .fwd_dest(fwd_dest),
    .fwd_data(fwd_data), .fwd_ready(fwd_ready), .issue_fire(issue_fire),
    .issue_long(issue_long), .wb_long_done(wb_long_done), .wb_long_dest(wb_long_dest),
    .md_start(md_start), .stall(stall), .md_busy(md_busy), .sb_pending(sb_pending),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              reset, id_valid, id_we, id_hilo;
    logic [AW-1:0]     rd_addr [NRP];
    logic [NRP-1:0]    rd_used;
    logic [DW-1:0]     rf_data [NRP];
    logic [AW-1:0]     id_dest;
    logic [NFS-1:0]    fwd_wena, fwd_ready;
    logic [AW-1:0]     fwd_dest [NFS];
    logic [DW-1:0]     fwd_data [NFS];
    logic              issue_fire, issue_long, wb_long_done, md_start;
    logic [AW-1:0]     wb_long_dest;
  } stim_t;

  typedef struct {
    logic [DW-1:0]   val [NRP];
    logic            stall, busy;
    logic [NREG-1:0] sb;
    logic [31:0]     scnt;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model state
  logic [NREG-1:0] m_sb;
  longint          m_cyc;
  longint          m_md_last;
  logic [31:0]     m_scnt;

  function automatic stim_t idle();
    stim_t s;
    s.reset = 0; s.id_valid = 0; s.id_we = 0; s.id_hilo = 0; s.id_dest = 0;
    s.rd_used = 0; s.fwd_wena = 0; s.fwd_ready = '1;
    s.issue_fire = 0; s.issue_long = 0; s.wb_long_done = 0; s.wb_long_dest = 0;
    s.md_start = 0;
    for (int p = 0; p < NRP; p++) begin s.rd_addr[p] = 0; s.rf_data[p] = $urandom; end
    for (int k = 0; k < NFS; k++) begin s.fwd_dest[k] = 0; s.fwd_data[k] = $urandom; end
    return s;
  endfunction

  function automatic stim_t rnd();
    stim_t s = idle();
    s.reset    = ($urandom_range(63) == 0);
    s.id_valid = ($urandom_range(3) != 0);
    s.id_we    = $urandom_range(1);
    s.id_dest  = AW'($urandom_range(7));
    s.id_hilo  = ($urandom_range(3) == 0);
    s.rd_used  = NRP'($urandom);
    for (int p = 0; p < NRP; p++) s.rd_addr[p] = AW'($urandom_range(7));
    s.fwd_wena  = NFS'($urandom);
    s.fwd_ready = NFS'($urandom) | NFS'($urandom);
    for (int k = 0; k < NFS; k++) s.fwd_dest[k] = AW'($urandom_range(7));
    s.issue_fire   = $urandom_range(1);
    s.issue_long   = ($urandom_range(2) == 0);
    s.wb_long_done = ($urandom_range(3) == 0);
    s.wb_long_dest = AW'($urandom_range(7));
    s.md_start     = ($urandom_range(15) == 0);
    return s;
  endfunction

  // Drive one cycle, predict outputs from the model, then advance the model.
  task automatic run(input stim_t s);
    exp_t   e;
    logic   found, hz, any_raw, waw, busy;
    reset = s.reset; id_valid = s.id_valid; id_we = s.id_we; id_dest = s.id_dest;
    id_hilo = s.id_hilo; rd_used = s.rd_used; fwd_wena = s.fwd_wena;
    fwd_ready = s.fwd_ready; issue_fire = s.issue_fire; issue_long = s.issue_long;
    wb_long_done = s.wb_long_done; wb_long_dest = s.wb_long_dest; md_start = s.md_start;
    for (int p = 0; p < NRP; p++) begin
      rd_addr[p*AW +: AW] = s.rd_addr[p];
      rf_data[p*DW +: DW] = s.rf_data[p];
    end
    for (int k = 0; k < NFS; k++) begin
      fwd_dest[k*AW +: AW] = s.fwd_dest[k];
      fwd_data[k*DW +: DW] = s.fwd_data[k];
    end

    any_raw = 0;
    for (int p = 0; p < NRP; p++) begin
      found = 0; hz = 0; e.val[p] = s.rf_data[p];
      if (s.rd_addr[p] != 0) begin
        for (int k = 0; k < NFS; k++) begin
          if (!found && s.fwd_wena[k] && s.fwd_dest[k] == s.rd_addr[p]) begin
            found = 1; e.val[p] = s.fwd_data[k]; hz = !s.fwd_ready[k];
          end
        end
        if (!found && m_sb[s.rd_addr[p]]) hz = 1;
      end
      if (hz && s.rd_used[p]) any_raw = 1;
    end
    waw    = s.id_we && s.id_dest != 0 && m_sb[s.id_dest];
    busy   = (m_cyc >= m_md_last + 1) && (m_cyc <= m_md_last + MD - 1);
    e.stall = s.id_valid && (any_raw || waw || (s.id_hilo && busy));
    e.busy  = busy;
    e.sb    = m_sb;
    e.scnt  = m_scnt;
    q.push_back(e);

    if (s.reset) begin
      m_sb = 0; m_md_last = -1000; m_scnt = 0;
    end else begin
      if (s.wb_long_done) m_sb[s.wb_long_dest] = 0;
      if (s.issue_fire && s.issue_long && s.id_we && s.id_dest != 0) m_sb[s.id_dest] = 1;
      if (s.md_start) m_md_last = m_cyc;
      if (e.stall && m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 1;
    end
    m_cyc++;
    @(posedge clk); #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every presented cycle against the queued prediction.
  exp_t me;
  always @(negedge clk) begin
    if (q.size() != 0) begin
      me = q.pop_front();
      for (int p = 0; p < NRP; p++)
        check($sformatf("rd_value%0d", p), 64'(rd_value[p*DW +: DW]), 64'(me.val[p]));
      check("stall", 64'(stall), 64'(me.stall));
      check("md_busy", 64'(md_busy), 64'(me.busy));
      check("sb_pending", 64'(sb_pending), 64'(me.sb));
      check("stall_cycles", 64'(stall_cycles), 64'(me.scnt));
    end
  end

  stim_t s;

  initial begin
    s = idle();
    s.reset = 1;
    reset = 1; id_valid = 0; id_we = 0; id_dest = 0; id_hilo = 0; rd_used = 0;
    rd_addr = 0; rf_data = 0; fwd_wena = 0; fwd_dest = 0; fwd_data = 0; fwd_ready = 0;
    issue_fire = 0; issue_long = 0; wb_long_done = 0; wb_long_dest = 0; md_start = 0;
    repeat (2) @(posedge clk);
    #1;
    m_sb = 0; m_md_last = -1000; m_scnt = 0; m_cyc = 0;

    // Reset state
    run(idle());

    // Forwarding priority: youngest stage wins, then older one after drop
    s = idle(); s.id_valid = 1; s.rd_addr[0] = 5; s.rd_used = 2'b01;
    s.fwd_wena = 3'b101; s.fwd_dest[0] = 5; s.fwd_dest[2] = 5;
    s.fwd_data[0] = 32'h11; s.fwd_data[2] = 32'h33;
    run(s);
    s.fwd_wena = 3'b100;
    run(s);

    // Load-use
    s = idle(); s.id_valid = 1; s.fwd_wena = 3'b001; s.fwd_dest[0] = 7;
    s.fwd_ready = 3'b110; s.rd_addr[1] = 7; s.rd_used = 2'b10;
    run(s);
    s.rd_used = 2'b00;
    run(s);
    s.rd_used = 2'b11; s.rd_addr[1] = 0; s.fwd_dest[0] = 0;
    run(s);

    // Scoreboard: long load to r9, RAW and WAW while pending, then retire
    s = idle(); s.id_valid = 1; s.id_we = 1; s.id_dest = 9;
    s.issue_fire = 1; s.issue_long = 1;
    run(s);
    s = idle(); s.id_valid = 1; s.rd_addr[0] = 9; s.rd_used = 2'b01;
    run(s); run(s);
    s = idle(); s.id_valid = 1; s.id_we = 1; s.id_dest = 9;
    run(s);
    s = idle(); s.id_valid = 1; s.rd_addr[0] = 9; s.rd_used = 2'b01;
    s.wb_long_done = 1; s.wb_long_dest = 9;
    run(s);
    s.wb_long_done = 0;
    run(s);
    // Same-cycle set and clear of r9
    s = idle(); s.id_we = 1; s.id_dest = 9; s.issue_fire = 1; s.issue_long = 1;
    run(s);
    s.wb_long_done = 1; s.wb_long_dest = 9;
    run(s);
    run(idle());

    // Mult/div occupancy with HI/LO consumer held
    s = idle(); s.md_start = 1;
    run(s);
    s = idle(); s.id_valid = 1; s.id_hilo = 1;
    repeat (MD + 1) run(s);

    // Reset mid-operation
    s = idle(); s.id_we = 1; s.id_dest = 3; s.issue_fire = 1; s.issue_long = 1; s.md_start = 1;
    run(s);
    s = idle(); s.reset = 1;
    run(s);
    run(idle());

    // Counter saturation: preload near the top, then hold a load-use stall
    force dut.r_stall_cnt = 32'hFFFF_FFFD;
    #0;
    release dut.r_stall_cnt;
    m_scnt = 32'hFFFF_FFFD;
    s = idle(); s.id_valid = 1; s.fwd_wena = 3'b001; s.fwd_dest[0] = 4;
    s.fwd_ready = 3'b000; s.rd_addr[0] = 4; s.rd_used = 2'b01;
    repeat (5) run(s);

    // Random traffic
    for (int i = 0; i < 800; i++) run(rnd());
    run(idle());

    for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain: got %0d queued expected 0", q.size());
    end
    @(negedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
